// File: rtl/m1_icache_pkg.sv
// Shared widths, FSM encoding and address field helpers for the direct-mapped instruction cache.
package m1_icache_pkg;

    localparam int ADDR_W     = 15;
    localparam int DATA_W     = 15;
    localparam int LINE_WORDS = 4;
    localparam int NUM_LINES  = 16;
    localparam int OFF_W      = $clog2(LINE_WORDS);
    localparam int IDX_W      = $clog2(NUM_LINES);
    localparam int TAG_W      = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        DONE   = 2'd2
    } icache_state_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic [OFF_W-1:0] off;
    } addr_fields_t;

    function automatic addr_fields_t split_addr(input logic [ADDR_W-1:0] addr);
        return addr_fields_t'(addr);
    endfunction

    function automatic logic [ADDR_W-1:0] join_addr(input logic [TAG_W-1:0] tag,
                                                    input logic [IDX_W-1:0] idx,
                                                    input logic [OFF_W-1:0] off);
        return {tag, idx, off};
    endfunction

endpackage

// File: rtl/icache_array_m1.sv
// Valid/tag/data storage: one word write port, one line (tag+valid) write port, async read, bulk valid clear.
module icache_array_m1
    import m1_icache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  rd_idx_i,
    input  logic [OFF_W-1:0]  rd_off_i,
    output logic              rd_valid_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              word_we_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [OFF_W-1:0]  wr_off_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              line_we_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic              wr_valid_i,
    input  logic              clear_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [DATA_W-1:0]    data_q [NUM_LINES][LINE_WORDS];

    // Data is reset too so the word read before any refill is a defined zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                tag_q[i] <= '0;
                for (int j = 0; j < LINE_WORDS; j++) begin
                    data_q[i][j] <= '0;
                end
            end
        end else begin
            if (word_we_i) begin
                data_q[wr_idx_i][wr_off_i] <= wr_data_i;
            end
            if (line_we_i) begin
                tag_q[wr_idx_i] <= wr_tag_i;
            end
        end
    end

    // A bulk clear overrides a same-cycle line validation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (clear_i) begin
            valid_q <= '0;
        end else if (line_we_i) begin
            valid_q[wr_idx_i] <= wr_valid_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i][rd_off_i];

endmodule

// File: rtl/icache_m1.sv
// Direct-mapped instruction cache: registered lookup address, combinational hit, line refill over req/ack.
// mem_req is held with a stable mem_addr until mem_ack; each ack returns one word and advances the word count.
module icache_m1
    import m1_icache_pkg::*;
(
    input  logic              clk,
    input  logic              async_rst_n,
    input  logic              clk_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              invalidate,
    output logic [DATA_W-1:0] instr_out,
    output logic              icache_miss,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [ADDR_W-1:0] lookup_q;
    icache_state_t     state_q;
    logic [TAG_W-1:0]  refill_tag_q;
    logic [IDX_W-1:0]  refill_idx_q;
    logic [OFF_W-1:0]  word_cnt_q;
    logic              mem_req_q;
    logic              inv_seen_q;

    addr_fields_t      lookup_f;
    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic              hit;
    logic              word_we;
    logic              last_word;
    logic              line_we;
    logic              line_valid;

    assign lookup_f = split_addr(lookup_q);

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            lookup_q <= '0;
        end else if (clk_en) begin
            lookup_q <= fetch_addr;
        end
    end

    // Refill writes are driven straight from the ack so the word lands on the same edge it is accepted.
    assign word_we    = (state_q == REFILL) && mem_ack;
    assign last_word  = (word_cnt_q == OFF_W'(LINE_WORDS - 1));
    assign line_we    = word_we && last_word;
    assign line_valid = !(inv_seen_q || invalidate);

    icache_array_m1 u_array (
        .clk        (clk),
        .rst_n      (async_rst_n),
        .rd_idx_i   (lookup_f.idx),
        .rd_off_i   (lookup_f.off),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (instr_out),
        .word_we_i  (word_we),
        .wr_idx_i   (refill_idx_q),
        .wr_off_i   (word_cnt_q),
        .wr_data_i  (mem_rdata),
        .line_we_i  (line_we),
        .wr_tag_i   (refill_tag_q),
        .wr_valid_i (line_valid),
        .clear_i    (invalidate)
    );

    assign hit         = rd_valid && (rd_tag == lookup_f.tag);
    assign icache_miss = !hit || (state_q != IDLE);

    // The FSM ignores clk_en so memory acks are never dropped while the pipeline is stalled.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q      <= IDLE;
            refill_tag_q <= '0;
            refill_idx_q <= '0;
            word_cnt_q   <= '0;
            mem_req_q    <= 1'b0;
            inv_seen_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!hit) begin
                        refill_tag_q <= lookup_f.tag;
                        refill_idx_q <= lookup_f.idx;
                        word_cnt_q   <= '0;
                        mem_req_q    <= 1'b1;
                        inv_seen_q   <= 1'b0;
                        state_q      <= REFILL;
                    end
                end
                REFILL: begin
                    if (invalidate) begin
                        inv_seen_q <= 1'b1;
                    end
                    if (mem_ack) begin
                        word_cnt_q <= word_cnt_q + 1'b1;
                        if (last_word) begin
                            mem_req_q <= 1'b0;
                            state_q   <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = join_addr(refill_tag_q, refill_idx_q, word_cnt_q);

endmodule
